// File: rtl/sr04_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sr04_pkg                                                   |
// | Brief   : Shared HC-SR04 state encoding and cm/us scaling constants. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package sr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam int c_CLK_FREQ   = 100_000_000;
    localparam int c_US_PER_CM  = 58;
    localparam int c_MIN_CM     = 2;
    localparam int c_MAX_CM     = 400;
    localparam int c_TIMEOUT_US = 38000;

    function automatic int ticks_per_us(input int clk_freq);
        return clk_freq / 1_000_000;
    endfunction

    // Echo width in whole us; the clamped product always fits 16 bits.
    function automatic logic [15:0] echo_width_us(
        input logic [8:0] dist_cm,
        input logic       obj_present,
        input int         min_cm,
        input int         max_cm,
        input int         us_per_cm,
        input int         timeout_us
    );
        int d;
        d = int'({23'd0, dist_cm});
        if (d < min_cm) d = min_cm;
        if (d > max_cm) d = max_cm;
        return obj_present ? 16'(d * us_per_cm) : 16'(timeout_us);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr04_echo_emulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sr04_echo_emulator_if                                      |
// | Brief   : trig/echo link between an SR04 controller and the sensor.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface sr04_echo_emulator_if;
    logic       trig;
    logic [8:0] dist_cm;
    logic       obj_present;
    logic       echo;
    logic       busy;
    logic       trig_err;

    modport master (
        output trig, dist_cm, obj_present,
        input  echo, busy, trig_err
    );

    modport slave (
        input  trig, dist_cm, obj_present,
        output echo, busy, trig_err
    );
endinterface
`default_nettype wire

// File: rtl/sr04_echo_emulator_us_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : us_tick_gen                                                |
// | Brief   : One-cycle pulse every TICKS_PER_US clocks, restart on clr. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module us_tick_gen #(
    parameter int TICKS_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int             c_CW   = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICKS_PER_US - 1);

    logic [c_CW-1:0] r_cnt;

    assign tick = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sr04_echo_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sr04_echo_emulator                                         |
// | Brief   : HC-SR04 device-side responder: trig in, scaled echo out.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sr04_echo_emulator
    import sr04_pkg::*;
#(
    parameter int CLK_FREQ    = c_CLK_FREQ,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = c_US_PER_CM,
    parameter int MIN_CM      = c_MIN_CM,
    parameter int MAX_CM      = c_MAX_CM,
    parameter int TIMEOUT_US  = c_TIMEOUT_US,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic                 clk,
    input  logic                 rst,
    sr04_echo_emulator_if.slave  bus
);
    localparam int          c_TICKS_PER_US = ticks_per_us(CLK_FREQ);
    localparam logic [15:0] c_TRIG_MIN     = 16'(TRIG_MIN_US);
    localparam logic [15:0] c_BURST_LAST   = 16'(BURST_US - 1);
    localparam logic [15:0] c_HOLDOFF_LAST = 16'(HOLDOFF_US - 1);

    state_t      r_state, w_state_next;
    logic        r_trig_meta, r_trig_s, r_trig_d, r_rise, r_fall;
    logic [15:0] r_us_cnt, w_us_eff, r_width, w_width_last;
    logic        r_echo, r_trig_err;
    logic        w_tick, w_entry, w_latch, w_err;

    // Edges are registered so the FSM acts three clocks after trig is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_meta <= 1'b0;
            r_trig_s    <= 1'b0;
            r_trig_d    <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_trig_meta <= bus.trig;
            r_trig_s    <= r_trig_meta;
            r_trig_d    <= r_trig_s;
            r_rise      <= r_trig_s & ~r_trig_d;
            r_fall      <= ~r_trig_s & r_trig_d;
        end
    end

    us_tick_gen #(
        .TICKS_PER_US (c_TICKS_PER_US)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_entry),
        .tick (w_tick)
    );

    // Includes the tick arriving this cycle so a trig of exactly N us reads N.
    assign w_us_eff     = (w_tick && (r_us_cnt != 16'hFFFF)) ? r_us_cnt + 16'd1 : r_us_cnt;
    assign w_width_last = r_width - 16'd1;
    assign w_entry      = (w_state_next != r_state);

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rise) w_state_next = ST_TRIG_HI;
            end
            ST_TRIG_HI: begin
                if (r_fall) begin
                    if (w_us_eff >= c_TRIG_MIN) begin
                        w_state_next = ST_BURST;
                        w_latch      = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_err        = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (w_tick && (r_us_cnt == c_BURST_LAST)) w_state_next = ST_ECHO;
            end
            ST_ECHO: begin
                if (w_tick && (r_us_cnt == w_width_last)) w_state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (w_tick && (r_us_cnt == c_HOLDOFF_LAST)) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_us_cnt   <= 16'd0;
            r_width    <= 16'd0;
            r_echo     <= 1'b0;
            r_trig_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_us_cnt   <= w_entry ? 16'd0 : w_us_eff;
            r_echo     <= (w_state_next == ST_ECHO);
            r_trig_err <= w_err;
            if (w_latch) begin
                r_width <= echo_width_us(bus.dist_cm, bus.obj_present,
                                         MIN_CM, MAX_CM, US_PER_CM, TIMEOUT_US);
            end
        end
    end

    assign bus.echo     = r_echo;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.trig_err = r_trig_err;
endmodule
`default_nettype wire

// File: tb/tb_sr04_echo_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sr04_echo_emulator                                      |
// | Brief   : Directed shots against a window-based model of the sensor. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_sr04_echo_emulator;
    localparam int c_T       = 4;      // clocks per us
    localparam int c_TRIGMIN = 10;
    localparam int c_BURST   = 20;
    localparam int c_USPCM   = 58;
    localparam int c_MINCM   = 2;
    localparam int c_MAXCM   = 40;
    localparam int c_TIMEOUT = 3000;
    localparam int c_HOLD    = 100;
    localparam int c_BIG     = 32'h7fff_ffff;

    logic clk, rst;
    int   cyc = 0;
    int   n_checks = 0, n_errors = 0;

    // Expected-output windows: output is 1 after edge k when start <= k < end.
    int busy_s = 0, busy_e = 0, echo_s = 0, echo_e = 0, err_k = -1;
    int last_e0 = 0;
    int rise_cyc = 0, last_width = 0, falls = 0;

    sr04_echo_emulator_if bus ();

    sr04_echo_emulator #(
        .CLK_FREQ    (c_T * 1_000_000),
        .TRIG_MIN_US (c_TRIGMIN),
        .BURST_US    (c_BURST),
        .US_PER_CM   (c_USPCM),
        .MIN_CM      (c_MINCM),
        .MAX_CM      (c_MAXCM),
        .TIMEOUT_US  (c_TIMEOUT),
        .HOLDOFF_US  (c_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int model_width_us();
        int d;
        d = int'(bus.dist_cm);
        if (!bus.obj_present) return c_TIMEOUT;
        if (d < c_MINCM) d = c_MINCM;
        if (d > c_MAXCM) d = c_MAXCM;
        return d * c_USPCM;
    endfunction

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive an n-clock trig pulse; ign leaves the model untouched (pulse must be ignored).
    task automatic fire(input int n, input bit ign);
        int er;
        @(posedge clk);
        #1;
        bus.trig = 1'b1;
        er = cyc + 1;
        if (!ign) begin
            busy_s = er + 3;
            busy_e = c_BIG;
        end
        repeat (n) @(posedge clk);
        #1;
        bus.trig = 1'b0;
        last_e0 = cyc + 1;
        if (!ign) begin
            if (n / c_T >= c_TRIGMIN) begin
                echo_s = last_e0 + 3 + c_BURST * c_T;
                echo_e = echo_s + model_width_us() * c_T;
                busy_e = echo_e + c_HOLD * c_T;
            end else begin
                busy_e = last_e0 + 3;
                err_k  = last_e0 + 3;
            end
        end
    endtask

    task automatic run_shot(input string name, input int n, input int exp_width_cyc);
        int f0;
        f0 = falls;
        fire(n, 1'b0);
        goto(busy_e + 2);
        if (exp_width_cyc > 0) begin
            check({name, " echo count"}, falls, f0 + 1);
            check({name, " echo width"}, last_width, exp_width_cyc);
            check({name, " echo delay"}, rise_cyc - last_e0, 83);
        end else begin
            check({name, " no echo"}, falls, f0);
        end
    endtask

    // Per-cycle comparison of every output against the model windows.
    initial begin
        forever begin
            @(negedge clk);
            check("echo",     int'(bus.echo),     int'(cyc >= echo_s && cyc < echo_e));
            check("busy",     int'(bus.busy),     int'(cyc >= busy_s && cyc < busy_e));
            check("trig_err", int'(bus.trig_err), int'(cyc == err_k));
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.echo && !prev) rise_cyc = cyc;
            if (!bus.echo && prev) begin
                last_width = cyc - rise_cyc;
                falls++;
            end
            prev = bus.echo;
        end
    end

    initial begin
        int f0, r;
        rst             = 1'b1;
        bus.trig        = 1'b0;
        bus.dist_cm     = 9'd10;
        bus.obj_present = 1'b1;
        goto(4);
        rst = 1'b0;
        check("reset echo",     int'(bus.echo),     0);
        check("reset busy",     int'(bus.busy),     0);
        check("reset trig_err", int'(bus.trig_err), 0);

        run_shot("12us d10", 48, 2320);
        run_shot("5us short", 20, 0);
        run_shot("39clk short", 39, 0);
        run_shot("10us exact", 40, 2320);

        bus.dist_cm = 9'd0;
        run_shot("d0 clamp", 48, 464);
        bus.dist_cm = 9'd500;
        run_shot("d500 clamp", 48, 9280);
        bus.obj_present = 1'b0;
        run_shot("no object", 48, 12000);
        bus.obj_present = 1'b1;

        // Distance change during BURST must not affect the latched width.
        bus.dist_cm = 9'd10;
        f0 = falls;
        fire(48, 1'b0);
        goto(last_e0 + 3 + 40);
        bus.dist_cm = 9'd100;
        goto(busy_e + 2);
        check("late dist count", falls, f0 + 1);
        check("late dist width", last_width, 2320);
        bus.dist_cm = 9'd10;

        // Trig during HOLDOFF is ignored; the next one after it is served.
        f0 = falls;
        fire(48, 1'b0);
        goto(echo_e + 20);
        fire(48, 1'b1);
        goto(busy_e + 2);
        check("holdoff trig count", falls, f0 + 1);
        run_shot("after holdoff", 48, 2320);

        // Rise landing on the HOLDOFF expiry edge is dropped.
        f0 = falls;
        fire(48, 1'b0);
        goto(busy_e - 5);
        fire(60, 1'b1);
        goto(cyc + 20);
        check("expiry rise count", falls, f0 + 1);

        run_shot("long trig", 1000, 2320);

        // One-cycle reset in the middle of an echo.
        fire(48, 1'b0);
        goto(echo_s + 100);
        @(posedge clk);
        #1;
        rst = 1'b1;
        r = cyc + 1;
        echo_e = r;
        busy_e = r;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst echo", int'(bus.echo), 0);
        check("rst busy", int'(bus.busy), 0);
        goto(r + 5);
        run_shot("post-rst 10us", 40, 2320);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
